// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port round-robin arbiter in front of a single-port SRAM macro
// Clears the whole SRAM after reset, then serialises both ports onto the macro.
module sram_port_arbiter #(
  parameter int Bits       = 64,
  parameter int Word_Depth = 512,
  parameter int Add_Width  = 9
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 p0_req_valid,
  output logic                 p0_req_ready,
  input  logic                 p0_req_write,
  input  logic [Add_Width-1:0] p0_req_addr,
  input  logic [Bits-1:0]      p0_req_wdata,
  output logic                 p0_resp_valid,
  input  logic                 p0_resp_ready,
  output logic [Bits-1:0]      p0_resp_rdata,
  input  logic                 p1_req_valid,
  output logic                 p1_req_ready,
  input  logic                 p1_req_write,
  input  logic [Add_Width-1:0] p1_req_addr,
  input  logic [Bits-1:0]      p1_req_wdata,
  output logic                 p1_resp_valid,
  input  logic                 p1_resp_ready,
  output logic [Bits-1:0]      p1_resp_rdata,
  output logic                 init_done,
  output logic                 sram_ceb,
  output logic                 sram_web,
  output logic [Add_Width-1:0] sram_a,
  output logic [Bits-1:0]      sram_d,
  input  logic [Bits-1:0]      sram_q
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [Add_Width-1:0] LastAddr = Add_Width'(Word_Depth - 1);

  state_e               state_q;
  logic [Add_Width-1:0] cnt_q;
  logic                 rr_q;
  logic                 pend0_q, pend1_q;
  logic                 rv0_q, rv1_q;
  logic [Bits-1:0]      rd0_q, rd1_q;

  logic run, elig0, elig1, gnt0, gnt1;

  assign run = (state_q == RUN);

  // A read may only issue once the previous read's response slot is free or being drained.
  assign elig0 = run & p0_req_valid &
                 (p0_req_write | (~pend0_q & (~rv0_q | p0_resp_ready)));
  assign elig1 = run & p1_req_valid &
                 (p1_req_write | (~pend1_q & (~rv1_q | p1_resp_ready)));

  // rr_q=1 means port 1 has priority on the next conflict.
  assign gnt0 = elig0 & (~elig1 | ~rr_q);
  assign gnt1 = elig1 & (~elig0 | rr_q);

  assign p0_req_ready  = gnt0;
  assign p1_req_ready  = gnt1;
  assign p0_resp_valid = rv0_q;
  assign p1_resp_valid = rv1_q;
  assign p0_resp_rdata = rd0_q;
  assign p1_resp_rdata = rd1_q;
  assign init_done     = run;

  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    // Gate the sweep with RSTB so the macro stays deselected while reset is held.
    if (state_q == INIT && RSTB) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = cnt_q;
    end else if (gnt0) begin
      sram_ceb = 1'b0;
      sram_web = ~p0_req_write;
      sram_a   = p0_req_addr;
      sram_d   = p0_req_wdata;
    end else if (gnt1) begin
      sram_ceb = 1'b0;
      sram_web = ~p1_req_write;
      sram_a   = p1_req_addr;
      sram_d   = p1_req_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      if (state_q == INIT) begin
        cnt_q <= cnt_q + Add_Width'(1);
        if (cnt_q == LastAddr) state_q <= RUN;
      end

      if (gnt0 | gnt1) rr_q <= gnt0;

      pend0_q <= gnt0 & ~p0_req_write;
      pend1_q <= gnt1 & ~p1_req_write;

      // A capture on the same edge as a consume keeps the response valid.
      if (pend0_q) begin
        rd0_q <= sram_q;
        rv0_q <= 1'b1;
      end else if (p0_resp_ready) begin
        rv0_q <= 1'b0;
      end

      if (pend1_q) begin
        rd1_q <= sram_q;
        rv1_q <= 1'b1;
      end else if (p1_resp_ready) begin
        rv1_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter Bits, default 64, data word width.
REQ-002 SHALL have parameter Word_Depth, default 512, SRAM words.
REQ-003 SHALL have parameter Add_Width, default 9, address width (2^Add_Width == Word_Depth).
REQ-004 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port RSTB  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports p0_req_valid / p1_req_valid  input  1  request present.
REQ-007 SHALL have ports p0_req_ready / p1_req_ready  output  1  request accepted this cycle (combinational).
REQ-008 SHALL have ports p0_req_write / p1_req_write  input  1  1=write, 0=read.
REQ-009 SHALL have ports p0_req_addr / p1_req_addr  input  Add_Width  word address.
REQ-010 SHALL have ports p0_req_wdata / p1_req_wdata  input  Bits  write data.
REQ-011 SHALL have ports p0_resp_valid / p1_resp_valid  output  1  read data held.
REQ-012 SHALL have ports p0_resp_ready / p1_resp_ready  input  1  requester consumes response.
REQ-013 SHALL have ports p0_resp_rdata / p1_resp_rdata  output  Bits  registered read data.
REQ-014 SHALL have port init_done  output  1  SRAM clear sweep complete.
REQ-015 SHALL have ports sram_ceb, sram_web  output  1  active-low chip/write enable to the single-port macro.
REQ-016 SHALL have ports sram_a  output  Add_Width, sram_d  output  Bits, sram_q  input  Bits (valid cycle after a read enable).

Function
REQ-017 SHALL implement states INIT and RUN; RSTB deassertion enters INIT with sweep counter 0.
REQ-018 INIT SHALL drive sram_ceb=0, sram_web=0, sram_a=counter, sram_d=0 each cycle, counter +1 per cycle.
REQ-019 After the cycle writing address Word_Depth-1, state SHALL become RUN and init_done SHALL rise (Word_Depth INIT cycles total).
REQ-020 In INIT both req_ready SHALL be 0.
REQ-021 In RUN a port SHALL be eligible when req_valid=1 and (req_write=1, or its read-pending flag=0 and (resp_valid=0 or resp_ready=1)).
REQ-022 Exactly one eligible port SHALL be granted per cycle; the granted port's req_ready=1, the other's 0.
REQ-023 Conflict (both eligible) SHALL be resolved round-robin: port not granted on the most recent grant wins; pointer updates only on a grant; port 0 wins the first conflict after reset.
REQ-024 A grant SHALL drive sram_ceb=0, sram_web=!req_write, sram_a=req_addr, sram_d=req_wdata in the same cycle.
REQ-025 No grant SHALL drive sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
REQ-026 Read grant in cycle T SHALL set that port's read-pending flag for cycle T+1, capture sram_q into resp_rdata at end of T+1, assert resp_valid from T+2.
REQ-027 resp_valid SHALL hold with stable resp_rdata until a cycle with resp_ready=1; it then clears unless a new capture occurs the same edge (capture wins, resp_valid stays 1).
REQ-028 Writes SHALL produce no response; completion is the req_ready handshake.
REQ-029 sram_q SHALL be sampled only in the cycle following a read grant; other values ignored.
REQ-030 Same-address write then read SHALL return the new data (serialised by the single port).

Reset
REQ-031 While RSTB=0: state INIT, counter 0, init_done 0, req_ready 0, resp_valid 0, resp_rdata 0, pending flags 0, RR pointer favours port 0, sram_ceb=1, sram_web=1.
REQ-032 RSTB assertion mid-operation SHALL discard pending reads and undelivered responses, then rerun the full INIT sweep.

Verification
REQ-033 Reset release, Word_Depth=512 -> 512 consecutive writes of 0 to addresses 0..511, init_done=1 in cycle 513, no ready before.
REQ-034 Port0 write addr 5 data 0xA5A5, then read addr 5 -> resp_valid two cycles after the read grant, p0_resp_rdata=0xA5A5.
REQ-035 Both ports read every cycle, resp_ready=1 -> grants alternate P0,P1,P0,...; sram_ceb=0 every cycle; each port gets one response every 2 cycles.
REQ-036 P0 resp_ready=0 with response held -> P0 read not granted, P1 reads granted; P0 resp_rdata stable until resp_ready=1.
REQ-037 Unread address after INIT (e.g. 300) -> read returns 0.
REQ-038 RSTB pulsed low one cycle after a read grant -> no resp_valid, init_done=0, fresh 512-cycle sweep.
